// File: rtl/uart_bus_pkg.sv
// Shared command/reply byte codes and FSM state encoding for the UART bus master.
package uart_bus_pkg;

  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'h45;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    REQ,
    WAIT_RV,
    RESP
  } state_t;

endpackage

// File: rtl/uart_bus_master.sv
// UART-driven single-word bus initiator: parses R/W command frames from the
// receiver byte stream, runs one req/gnt/rvalid transaction and replies over UART.
module uart_bus_master
  import uart_bus_pkg::*;
#(
  parameter int RSP_TIMEOUT   = 1024,
  parameter int FRAME_TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        tx_start_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_busy_i,
  output logic        bus_req_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_err_i,
  output logic        busy_o
);

  localparam int RSP_W = $clog2(RSP_TIMEOUT + 1);
  localparam int FRM_W = $clog2(FRAME_TIMEOUT + 1);
  localparam logic [RSP_W-1:0] RSP_LAST = RSP_W'(RSP_TIMEOUT - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAME_TIMEOUT - 1);

  state_t           state;
  logic             is_write;
  logic [1:0]       byte_idx;
  logic [31:0]      addr_sr;
  logic [31:0]      wdata_sr;
  logic [31:0]      reply_sr;
  logic [2:0]       bytes_left;
  logic             tx_guard;
  logic [RSP_W-1:0] rsp_cnt;
  logic [FRM_W-1:0] frame_cnt;
  logic [31:0]      reply_word;
  logic [2:0]       reply_len;

  assign busy_o      = (state != IDLE);
  assign bus_be_o    = 4'hF;
  assign bus_we_o    = is_write;
  assign bus_addr_o  = {addr_sr[31:2], 2'b00};
  assign bus_wdata_o = wdata_sr;
  assign tx_data_o   = reply_sr[7:0];

  // Busy is checked in the same cycle as the pulse so a byte never launches into a busy transmitter.
  assign tx_start_o = (state == RESP) && (bytes_left != 3'd0) && !tx_guard && !tx_busy_i;

  // Reply chosen at the end of WAIT_RV; anything other than a clean rvalid means 'E'.
  always_comb begin
    reply_word = {24'h0, RSP_ERR};
    reply_len  = 3'd1;
    if (bus_rvalid_i && !bus_err_i) begin
      if (is_write) begin
        reply_word = {24'h0, RSP_OK};
      end else begin
        reply_word = bus_rdata_i;
        reply_len  = 3'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      is_write   <= 1'b0;
      byte_idx   <= 2'd0;
      addr_sr    <= 32'h0;
      wdata_sr   <= 32'h0;
      reply_sr   <= 32'h0;
      bytes_left <= 3'd0;
      tx_guard   <= 1'b0;
      rsp_cnt    <= '0;
      frame_cnt  <= '0;
      bus_req_o  <= 1'b0;
    end else begin
      tx_guard <= tx_start_o;
      unique case (state)
        IDLE: begin
          if (rx_valid_i && (rx_data_i == CMD_READ || rx_data_i == CMD_WRITE)) begin
            is_write  <= (rx_data_i == CMD_WRITE);
            byte_idx  <= 2'd0;
            frame_cnt <= '0;
            state     <= ADDR;
          end
        end
        ADDR, WDATA: begin
          if (rx_valid_i) begin
            frame_cnt <= '0;
            byte_idx  <= byte_idx + 2'd1;
            if (state == ADDR) addr_sr  <= {rx_data_i, addr_sr[31:8]};
            else               wdata_sr <= {rx_data_i, wdata_sr[31:8]};
            if (byte_idx == 2'd3) begin
              if (state == ADDR && is_write) begin
                state <= WDATA;
              end else begin
                state     <= REQ;
                bus_req_o <= 1'b1;
              end
            end
          end else if (frame_cnt == FRM_LAST) begin
            state <= IDLE;
          end else begin
            frame_cnt <= frame_cnt + FRM_W'(1);
          end
        end
        REQ: begin
          if (bus_gnt_i) begin
            bus_req_o <= 1'b0;
            rsp_cnt   <= RSP_W'(1);
            state     <= WAIT_RV;
          end
        end
        WAIT_RV: begin
          if (bus_rvalid_i || rsp_cnt == RSP_LAST) begin
            reply_sr   <= reply_word;
            bytes_left <= reply_len;
            state      <= RESP;
          end else begin
            rsp_cnt <= rsp_cnt + RSP_W'(1);
          end
        end
        RESP: begin
          if (bytes_left == 3'd0) begin
            state <= IDLE;
          end else if (tx_start_o) begin
            reply_sr   <= {8'h00, reply_sr[31:8]};
            bytes_left <= bytes_left - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master: frame-level reference model, bus responder
// and transmitter stand-in, with a single per-cycle compare process.
module tb_uart_bus_master;

  localparam int RSP_TO   = 8;
  localparam int FRAME_TO = 16;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid_i;
  logic [7:0]  rx_data_i;
  logic        tx_start_o;
  logic [7:0]  tx_data_o;
  logic        tx_busy_i;
  logic        bus_req_o;
  logic        bus_gnt_i;
  logic        bus_rvalid_i;
  logic        bus_we_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_err_i;
  logic        busy_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  txn_t       exp_bus[$];
  logic [7:0] exp_tx[$];
  logic [7:0] tx_log[$];
  txn_t       gnt_log[$];
  logic [31:0] model_mem[logic [31:0]];
  logic [31:0] bus_mem[logic [31:0]];

  int gnt_stall = 0, stall_cnt = 0, late_delay = 12, rv_delay = 0, rv_count = 0;
  bit resp_err = 0, resp_drop = 0, rv_pending = 0, bp_en = 0;
  logic [31:0] rv_data;
  int busy_cnt = 0, tx_pulses = 0, stall_cycles = 0, gnt_cyc = 0, last_tx_cyc = 0;
  bit start_seen = 0, arm = 0;

  uart_bus_master #(.RSP_TIMEOUT(RSP_TO), .FRAME_TIMEOUT(FRAME_TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
    .tx_start_o(tx_start_o), .tx_data_o(tx_data_o), .tx_busy_i(tx_busy_i),
    .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
    .bus_we_o(bus_we_o), .bus_be_o(bus_be_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Bus responder: optional grant stall, rvalid one cycle after grant, or a late/dropped response.
  initial begin
    bus_gnt_i = 0; bus_rvalid_i = 0; bus_err_i = 0; bus_rdata_i = 0;
    forever begin
      @(posedge clk); #1;
      bus_gnt_i = 0; bus_rvalid_i = 0; bus_err_i = 0;
      if (!rst_n) begin
        rv_pending = 0; stall_cnt = 0;
      end else if (rv_pending) begin
        if (rv_delay == 0) begin
          bus_rvalid_i = 1; bus_err_i = resp_err; bus_rdata_i = rv_data;
          rv_pending = 0; rv_count++;
        end else rv_delay--;
      end else if (bus_req_o) begin
        if (stall_cnt < gnt_stall) stall_cnt++;
        else begin
          bus_gnt_i = 1; stall_cnt = 0;
          if (bus_we_o) bus_mem[bus_addr_o] = bus_wdata_o;
          rv_data = bus_mem.exists(bus_addr_o) ? bus_mem[bus_addr_o] : 32'h0;
          rv_pending = 1;
          rv_delay = resp_drop ? late_delay : 0;
        end
      end
    end
  end

  // Transmitter stand-in: busy rises one cycle after a start (registered busy), plus optional random stalls.
  initial begin
    tx_busy_i = 0;
    forever begin
      @(posedge clk); #1;
      if (start_seen) begin
        start_seen = 0; arm = 1; tx_busy_i = 0;
      end else begin
        if (arm) begin arm = 0; busy_cnt = bp_en ? int'($urandom_range(2, 6)) : 3; end
        if (busy_cnt > 0) begin busy_cnt--; tx_busy_i = 1; end
        else if (bp_en && $urandom_range(0, 2) == 0) begin busy_cnt = $urandom_range(0, 3); tx_busy_i = 1; end
        else tx_busy_i = 0;
      end
    end
  end

  // Compare process: every cycle out of reset, checks tx and bus activity against the model queues.
  initial begin
    txn_t t;
    logic prev_req, prev_gnt, prev_we;
    logic [31:0] prev_addr, prev_wdata;
    prev_req = 0; prev_gnt = 0; prev_we = 0; prev_addr = 0; prev_wdata = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_req = 0;
        continue;
      end
      if (tx_start_o) begin
        start_seen = 1; tx_pulses++; last_tx_cyc = cyc;
        tx_log.push_back(tx_data_o);
        checkOutput("tx_start_while_busy", tx_busy_i, 0);
        checkOutput("tx_start_in_guard", arm, 0);
        if (exp_tx.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_tx actual=%0h required=none", tx_data_o);
        end else checkOutput("tx_data", tx_data_o, exp_tx.pop_front());
      end
      if (bus_req_o) begin
        checkOutput("addr_align", bus_addr_o[1:0], 0);
        checkOutput("byte_enable", bus_be_o, 4'hF);
        if (prev_req && !prev_gnt) begin
          checkOutput("req_stable_we", bus_we_o, prev_we);
          checkOutput("req_stable_addr", bus_addr_o, prev_addr);
          checkOutput("req_stable_wdata", bus_wdata_o, prev_wdata);
        end
        if (bus_gnt_i) begin
          gnt_cyc = cyc;
          t.we = bus_we_o; t.addr = bus_addr_o; t.wdata = bus_wdata_o;
          gnt_log.push_back(t);
          if (exp_bus.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL unexpected_bus actual=%0h required=none", bus_addr_o);
          end else begin
            t = exp_bus.pop_front();
            checkOutput("bus_we", bus_we_o, t.we);
            checkOutput("bus_addr", bus_addr_o, t.addr);
            if (t.we) checkOutput("bus_wdata", bus_wdata_o, t.wdata);
          end
        end else stall_cycles++;
      end
      prev_req = bus_req_o; prev_gnt = bus_gnt_i; prev_we = bus_we_o;
      prev_addr = bus_addr_o; prev_wdata = bus_wdata_o;
    end
  end

  // Frame-level model: what a complete frame must do to the bus and the reply stream.
  task automatic modelFrame(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data);
    txn_t t;
    logic [31:0] d;
    t.we = (cmd == 8'h57); t.addr = {addr[31:2], 2'b00}; t.wdata = data;
    exp_bus.push_back(t);
    if (resp_err || resp_drop) exp_tx.push_back(8'h45);
    else if (t.we) begin
      model_mem[t.addr] = data;
      exp_tx.push_back(8'h4B);
    end else begin
      d = model_mem.exists(t.addr) ? model_mem[t.addr] : 32'h0;
      for (int i = 0; i < 4; i++) exp_tx.push_back(d[8*i +: 8]);
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data_i = b; rx_valid_i = 1'b1;
    @(posedge clk); #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data,
                               input int nbytes, input bit wait_done);
    bit full, done;
    full = (cmd == 8'h52 && nbytes == 5) || (cmd == 8'h57 && nbytes == 9);
    if (full) modelFrame(cmd, addr, data);
    sendByte(cmd);
    for (int i = 0; i < 4 && i + 1 < nbytes; i++) sendByte(addr[8*i +: 8]);
    for (int i = 0; i < 4 && i + 5 < nbytes; i++) sendByte(data[8*i +: 8]);
    if (full) begin
      #1;
      checkOutput("req_latency", bus_req_o, 1);
      if (wait_done) begin
        done = 0;
        for (int k = 0; k < 400 && !done; k++) begin
          @(negedge clk);
          done = !busy_o;
        end
        checkOutput("frame_done", done, 1);
        checkOutput("tx_drained", exp_tx.size(), 0);
        checkOutput("bus_drained", exp_bus.size(), 0);
      end
    end
  endtask

  initial begin
    int p0, r0;
    rst_n = 0; rx_valid_i = 0; rx_data_i = 0;
    repeat (2) @(negedge clk);
    checkOutput("reset_outputs", {tx_start_o, tx_data_o, bus_req_o, bus_we_o, busy_o}, 0);
    checkOutput("reset_addr", bus_addr_o, 0);
    checkOutput("reset_wdata", bus_wdata_o, 0);
    @(posedge clk); #2; rst_n = 1;

    $display("[TB] write then read");
    applyStimulus(8'h57, 32'h10, 32'hDEADBEEF, 9, 1);
    applyStimulus(8'h52, 32'h10, 32'h0, 5, 1);
    checkOutput("t1_tx_count", tx_log.size(), 5);
    checkOutput("t1_tx_bytes", {tx_log[0], tx_log[1], tx_log[2], tx_log[3], tx_log[4]}, 40'h4B_EF_BE_AD_DE);
    checkOutput("t1_write_txn", {31'h0, gnt_log[0].we, gnt_log[0].addr}, 64'h1_0000_0010);
    checkOutput("t1_write_data", gnt_log[0].wdata, 32'hDEADBEEF);

    $display("[TB] misaligned read with grant stall");
    gnt_stall = 5; stall_cycles = 0; r0 = rv_count; p0 = tx_pulses;
    applyStimulus(8'h52, 32'h13, 32'h0, 5, 1);
    gnt_stall = 0;
    checkOutput("stall_cycles", stall_cycles, 5);
    checkOutput("stall_addr", gnt_log[gnt_log.size()-1].addr, 32'h10);
    checkOutput("stall_rvalids", rv_count - r0, 1);
    checkOutput("stall_pulses", tx_pulses - p0, 4);

    $display("[TB] bus error");
    resp_err = 1; p0 = tx_pulses;
    applyStimulus(8'h52, 32'h10, 32'h0, 5, 1);
    resp_err = 0;
    repeat (3) @(negedge clk);
    checkOutput("err_pulses", tx_pulses - p0, 1);
    checkOutput("err_byte", tx_log[tx_log.size()-1], 8'h45);
    checkOutput("err_busy_low", busy_o, 0);

    $display("[TB] response timeout");
    resp_drop = 1; r0 = rv_count;
    applyStimulus(8'h52, 32'h30, 32'h0, 5, 1);
    resp_drop = 0;
    checkOutput("timeout_latency", last_tx_cyc - gnt_cyc, RSP_TO);
    p0 = tx_pulses;
    repeat (20) @(negedge clk);
    checkOutput("late_rvalid_seen", rv_count - r0, 1);
    checkOutput("late_rvalid_no_tx", tx_pulses - p0, 0);
    checkOutput("late_rvalid_idle", busy_o, 0);

    $display("[TB] resync and frame timeout");
    p0 = tx_pulses; r0 = gnt_log.size();
    sendByte(8'h00);
    sendByte(8'h41);
    applyStimulus(8'h57, 32'h0000_2000, 32'h0, 3, 0);
    repeat (FRAME_TO - 1) @(posedge clk);
    applyStimulus(8'h52, 32'h10, 32'h0, 5, 1);
    checkOutput("resync_grants", gnt_log.size() - r0, 1);
    checkOutput("resync_pulses", tx_pulses - p0, 4);

    $display("[TB] tx backpressure");
    applyStimulus(8'h57, 32'h24, 32'h11223344, 9, 1);
    bp_en = 1; p0 = tx_pulses;
    applyStimulus(8'h52, 32'h24, 32'h0, 5, 1);
    bp_en = 0;
    checkOutput("bp_pulses", tx_pulses - p0, 4);
    checkOutput("bp_bytes", {tx_log[tx_log.size()-4], tx_log[tx_log.size()-3],
                             tx_log[tx_log.size()-2], tx_log[tx_log.size()-1]}, 32'h44332211);

    $display("[TB] async reset mid-transaction");
    gnt_stall = 100;
    applyStimulus(8'h52, 32'h40, 32'h0, 5, 0);
    repeat (3) @(posedge clk);
    #3; rst_n = 0; #1;
    checkOutput("areset_req", bus_req_o, 0);
    checkOutput("areset_busy", busy_o, 0);
    exp_bus.delete(); exp_tx.delete();
    @(posedge clk); #1; gnt_stall = 0;
    @(posedge clk); #2; rst_n = 1;
    repeat (5) @(negedge clk);
    checkOutput("areset_stays_idle", {bus_req_o, busy_o, tx_start_o}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    errors++;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
